// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered bitwise logic unit: op codes,
// handshake state encoding and a width-parameterised evaluation helper.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOT  = 3'b110,
        OP_PASS = 3'b111
    } op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Static-function wrapper so one definition serves every operand width.
    virtual class lu_fn #(parameter int unsigned W = 8);
        static function logic [W-1:0] apply(input op_t op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
            logic [W-1:0] r;
            unique case (op)
                OP_AND:  r = a & b;
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                OP_NAND: r = ~(a & b);
                OP_NOR:  r = ~(a | b);
                OP_XNOR: r = ~(a ^ b);
                OP_NOT:  r = ~a;
                OP_PASS: r = a;
                default: r = '0;
            endcase
            return r;
        endfunction
    endclass

endpackage

// File: rtl/logic_unit_core.sv
// Purely combinational bitwise function unit; no state, no handshake.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = lu_fn#(WIDTH)::apply(op, a, b);
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with valid/ready handshake, result-feedback chain
// mode and status flags derived from the output register.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned     WIDTH   = 8,
    parameter logic [WIDTH-1:0] RESET_Y = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             CHAIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic             ONES,
    output logic             PARITY
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] chain_q;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] result;
    logic             accept;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign b_eff     = CHAIN ? chain_q : B;

    logic_unit_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a  (A),
        .b  (b_eff),
        .op (op_t'(OP)),
        .y  (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // An accept always lands a result, so it wins over a same-cycle consume.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (accept)         state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= RESET_Y;
            chain_q <= RESET_Y;
        end else if (accept) begin
            y_q     <= result;
            chain_q <= result;
        end
    end

    assign Y      = y_q;
    assign ZERO   = (y_q == '0);
    assign ONES   = (y_q == '1);
    assign PARITY = ^y_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe (8-bit main instance plus
// 1-bit and 32-bit builds for the width-edge NOR case).
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       chain;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic       ones;
    logic       parity;

    logic        w1_in_ready, w1_out_valid, w1_zero, w1_ones, w1_parity;
    logic [0:0]  w1_y;
    logic        w32_in_ready, w32_out_valid, w32_zero, w32_ones, w32_parity;
    logic [31:0] w32_y;
    logic        wide_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .RESET_Y(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .OP(op), .CHAIN(chain), .out_valid(out_valid),
        .out_ready(out_ready), .Y(y), .ZERO(zero), .ONES(ones), .PARITY(parity)
    );

    logic_unit_pipe #(.WIDTH(1), .RESET_Y(1'b0)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(wide_valid), .in_ready(w1_in_ready),
        .A(1'b0), .B(1'b0), .OP(3'b100), .CHAIN(1'b0), .out_valid(w1_out_valid),
        .out_ready(1'b1), .Y(w1_y), .ZERO(w1_zero), .ONES(w1_ones), .PARITY(w1_parity)
    );

    logic_unit_pipe #(.WIDTH(32), .RESET_Y(32'h0)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(wide_valid), .in_ready(w32_in_ready),
        .A(32'h0), .B(32'h0), .OP(3'b100), .CHAIN(1'b0), .out_valid(w32_out_valid),
        .out_ready(1'b1), .Y(w32_y), .ZERO(w32_zero), .ONES(w32_ones), .PARITY(w32_parity)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       chain;
        logic [7:0] y;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply vectors lo..hi back to back, checking each result one edge later.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            a         = vecs[i].a;
            b         = vecs[i].b;
            op        = vecs[i].op;
            chain     = vecs[i].chain;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_y", i), {24'h0, y}, {24'h0, vecs[i].y});
            check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, 32'h1);
            check($sformatf("vec%0d_zero", i), {31'h0, zero}, {31'h0, vecs[i].y == 8'h00});
            check($sformatf("vec%0d_ones", i), {31'h0, ones}, {31'h0, vecs[i].y == 8'hFF});
            check($sformatf("vec%0d_parity", i), {31'h0, parity}, {31'h0, ^vecs[i].y});
        end
        @(negedge clk);
        in_valid = 1'b0;
        chain    = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{8'hF0, 8'h3C, 3'b000, 1'b0, 8'h30};
        vecs[1]  = '{8'hA5, 8'h0F, 3'b000, 1'b0, 8'h05};
        vecs[2]  = '{8'hA5, 8'h0F, 3'b001, 1'b0, 8'hAF};
        vecs[3]  = '{8'hA5, 8'h0F, 3'b010, 1'b0, 8'hAA};
        vecs[4]  = '{8'hA5, 8'h0F, 3'b011, 1'b0, 8'hFA};
        vecs[5]  = '{8'hA5, 8'h0F, 3'b100, 1'b0, 8'h50};
        vecs[6]  = '{8'hA5, 8'h0F, 3'b101, 1'b0, 8'h55};
        vecs[7]  = '{8'hA5, 8'h0F, 3'b110, 1'b0, 8'h5A};
        vecs[8]  = '{8'hA5, 8'h0F, 3'b111, 1'b0, 8'hA5};
        vecs[9]  = '{8'h01, 8'hEE, 3'b010, 1'b1, 8'h01};
        vecs[10] = '{8'h02, 8'hEE, 3'b010, 1'b1, 8'h03};
        vecs[11] = '{8'h04, 8'hEE, 3'b010, 1'b1, 8'h07};
        vecs[12] = '{8'h08, 8'hEE, 3'b010, 1'b1, 8'h0F};
        vecs[13] = '{8'hFF, 8'hEE, 3'b110, 1'b0, 8'h00};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        a          = 8'h00;
        b          = 8'h00;
        op         = 3'b000;
        chain      = 1'b0;
        wide_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_valid",  {31'h0, out_valid}, 32'h0);
        check("rst_y",      {24'h0, y}, 32'h0);
        check("rst_zero",   {31'h0, zero}, 32'h1);
        check("rst_ones",   {31'h0, ones}, 32'h0);
        check("rst_parity", {31'h0, parity}, 32'h0);
        check("rst_ready",  {31'h0, in_ready}, 32'h1);

        // Width-edge builds: NOR of zeros is all ones.
        @(negedge clk);
        wide_valid = 1'b1;
        @(posedge clk);
        #1;
        check("w1_y",      {31'h0, w1_y}, 32'h1);
        check("w1_ones",   {31'h0, w1_ones}, 32'h1);
        check("w1_parity", {31'h0, w1_parity}, 32'h1);
        check("w1_valid",  {31'h0, w1_out_valid}, 32'h1);
        check("w32_y",      w32_y, 32'hFFFF_FFFF);
        check("w32_ones",   {31'h0, w32_ones}, 32'h1);
        check("w32_zero",   {31'h0, w32_zero}, 32'h0);
        check("w32_parity", {31'h0, w32_parity}, 32'h0);
        @(negedge clk);
        wide_valid = 1'b0;

        // First beat, then full op sweep without bubbles.
        run_vecs(0, 8);

        // Chain fold from reset, ending in NOT.
        do_reset();
        run_vecs(9, 13);

        // Backpressure: hold result while a new beat waits.
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a = 8'h12; b = 8'h34; op = 3'b001;
        @(posedge clk);
        #1;
        check("bp_first_y", {24'h0, y}, 32'h36);
        check("bp_first_valid", {31'h0, out_valid}, 32'h1);
        check("bp_ready_low", {31'h0, in_ready}, 32'h0);
        @(negedge clk);
        a = 8'hC3; b = 8'h0F; op = 3'b000;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_y", c), {24'h0, y}, 32'h36);
            check($sformatf("bp_hold%0d_valid", c), {31'h0, out_valid}, 32'h1);
            check($sformatf("bp_hold%0d_ready", c), {31'h0, in_ready}, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_ready_comb", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("bp_next_y", {24'h0, y}, 32'h03);
        check("bp_next_valid", {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_drain_valid", {31'h0, out_valid}, 32'h0);
        check("bp_drain_y", {24'h0, y}, 32'h03);
        // Idle cycle with garbage operands must not disturb anything.
        @(negedge clk);
        a = 8'hXX; b = 8'hXX; op = 3'bxxx;
        @(posedge clk);
        #1;
        check("idle_y", {24'h0, y}, 32'h03);
        check("idle_valid", {31'h0, out_valid}, 32'h0);

        // Async reset mid-stream, then chain must restart from RESET_Y.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b0;
        a = 8'h81; b = 8'h00; op = 3'b111; chain = 1'b0;
        @(posedge clk);
        #1;
        check("ar_pre_y", {24'h0, y}, 32'h81);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'h0, out_valid}, 32'h0);
        check("ar_y", {24'h0, y}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        a = 8'h40; b = 8'hFF; op = 3'b001; chain = 1'b1;
        @(posedge clk);
        #1;
        check("ar_chain_y", {24'h0, y}, 32'h40);
        check("ar_chain_valid", {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        chain = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
